spi_flash_responder: RTL and testbench

Synthesizable SPI-flash emulator: the responder end of the SoC's bootloader SPI link. It answers the bootloader's read command with bytes taken from an internal word memory, preloaded through a simple write port. It is intended for FPGA builds without a physical flash part, and as a self-checking loopback peer for the SoC in simulation. SPI inputs are oversampled in the system clock domain; no SCK-domain logic exists.

---
 rtl/spi_flash_pkg.sv | 14 +
 rtl/spi_flash_responder_edge_sync.sv | 30 +++
 rtl/spi_flash_responder.sv | 150 +++++++++++++++
 tb/tb_spi_flash_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes and FSM state encoding for the SPI flash responder.
package spi_flash_pkg;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_IGNORE
  } state_t;
endpackage

// File: rtl/spi_flash_responder_edge_sync.sv
// 2-FF synchronizer with registered rise/fall strobes for an asynchronous SPI pin.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1;
  logic prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1   <= RST_VAL;
      q    <= RST_VAL;
      prev <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      q    <= s1;
      prev <= q;
      rise <= q & ~prev;
      fall <= ~q & prev;
    end
  end
endmodule

// File: rtl/spi_flash_responder.sv
// SPI-flash emulator answering READ (03h) and RDID (9Fh) from a preloadable word memory.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          DEPTH    = 512,
  parameter int          AW       = 9,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_spi_cs,
  input  logic          io_spi_clk,
  input  logic          io_spi_mosi,
  output logic          io_spi_miso,
  input  logic          mem_wr_en,
  input  logic [AW-1:0] mem_wr_addr,
  input  logic [31:0]   mem_wr_data,
  output logic          busy,
  output logic          cmd_err
);
  logic [31:0] mem [DEPTH];

  logic cs_q, cs_fall, cs_rise_unused;
  logic sck_lvl_unused, sck_rise, sck_fall;
  logic mosi_s1, mosi_s;

  state_t        state, next;
  logic          err;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [6:0]    cmd_sh;
  logic [AW+1:0] addr;
  logic [7:0]    tx;
  logic [7:0]    opcode;
  logic [31:0]   word;
  logic [7:0]    id_byte;
  logic [7:0]    out_byte;
  logic          load;

  spi_edge_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clock(clock), .reset(reset), .d(io_spi_cs),
    .q(cs_q), .rise(cs_rise_unused), .fall(cs_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b0)) u_sck_sync (
    .clock(clock), .reset(reset), .d(io_spi_clk),
    .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mosi_s1 <= 1'b0;
      mosi_s  <= 1'b0;
    end else begin
      mosi_s1 <= io_spi_mosi;
      mosi_s  <= mosi_s1;
    end
  end

  // Preload port; memory is intentionally left out of reset
  always_ff @(posedge clock) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  assign busy   = ~cs_q;
  assign opcode = {cmd_sh, mosi_s};
  assign word   = mem[addr[AW+1:2]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    err  = 1'b0;
    if (cs_q) begin
      next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) next = ST_CMD;
        ST_CMD: begin
          if (sck_rise && bit_cnt == 3'd7) begin
            case (opcode)
              CMD_READ: next = ST_ADDR;
              CMD_RDID: next = ST_ID;
              default: begin
                next = ST_IGNORE;
                err  = 1'b1;
              end
            endcase
          end
        end
        ST_ADDR: if (sck_rise && bit_cnt == 3'd7 && byte_cnt == 2'd2) next = ST_DATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    id_byte = 8'h00;
    case (byte_cnt)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
    out_byte = (state == ST_DATA) ? word[{addr[1:0], 3'b000} +: 8] : id_byte;
    load     = sck_fall && bit_cnt == 3'd0 && (state == ST_DATA || state == ST_ID);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_err     <= 1'b0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      cmd_sh      <= '0;
      addr        <= '0;
      tx          <= '0;
      io_spi_miso <= 1'b0;
    end else begin
      cmd_err <= err;
      if (cs_q || cs_fall) begin
        bit_cnt     <= '0;
        byte_cnt    <= '0;
        tx          <= '0;
        io_spi_miso <= 1'b0;
      end else begin
        if (sck_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (state == ST_CMD) cmd_sh <= opcode[6:0];
          // Only the low AW+2 address bits survive the shift; the rest wrap away
          if (state == ST_ADDR) begin
            addr <= {addr[AW:0], mosi_s};
            if (bit_cnt == 3'd7) byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
          end
        end
        if (load) begin
          tx          <= out_byte;
          io_spi_miso <= out_byte[7];
          if (state == ST_DATA) addr <= addr + 1'b1;
          if (state == ST_ID && byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
        end else if (sck_fall && (state == ST_DATA || state == ST_ID)) begin
          tx          <= {tx[6:0], 1'b0};
          io_spi_miso <= tx[6];
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: bit-banged SPI initiator plus a byte-level flash model.
module tb_spi_flash_responder;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cs = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic          miso, busy, cmd_err;
  logic          mem_wr_en = 1'b0;
  logic [AW-1:0] mem_wr_addr = '0;
  logic [31:0]   mem_wr_data = '0;

  int vectors = 0, miscompares = 0, err_pulses = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] model_mem[DEPTH];
  logic        rx_vld = 1'b0;
  logic [7:0]  rx_byte = '0;

  always #5 clock = ~clock;

  spi_flash_responder #(.DEPTH(DEPTH), .AW(AW), .JEDEC_ID(24'hEF4016)) dut (
    .clock(clock), .reset(reset),
    .io_spi_cs(cs), .io_spi_clk(sck), .io_spi_mosi(mosi), .io_spi_miso(miso),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .cmd_err(cmd_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clock) begin : monitor
    logic [7:0] e;
    if (rx_vld) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rx_byte: got %h with nothing expected", rx_byte);
      end else begin
        e = exp_q.pop_front();
        if (rx_byte !== e) begin
          miscompares++;
          $display("FAIL rx_byte: got %h expected %h", rx_byte, e);
        end
      end
    end
  end

  always @(negedge clock) if (cmd_err === 1'b1) err_pulses++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_byte(input int unsigned a);
    int unsigned ba;
    logic [31:0] w;
    ba = a % (DEPTH * 4);
    w  = model_mem[ba / 4];
    return w[(ba % 4) * 8 +: 8];
  endfunction

  task automatic wr_word(input int unsigned wa, input logic [31:0] d);
    @(negedge clock);
    mem_wr_en = 1'b1; mem_wr_addr = wa[AW-1:0]; mem_wr_data = d;
    model_mem[wa] = d;
    @(negedge clock);
    mem_wr_en = 1'b0;
  endtask

  task automatic send_bit(input logic b, output logic r);
    mosi = b;
    repeat (6) @(negedge clock);
    r = miso;
    sck = 1'b1;
    repeat (6) @(negedge clock);
    sck = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] t);
    logic [7:0] r;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      send_bit(t[i], b);
      r[i] = b;
    end
    rx_byte = r; rx_vld = 1'b1;
    @(negedge clock);
    rx_vld = 1'b0;
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    repeat (8) @(negedge clock);
    check("busy_active", busy, 1'b1);
  endtask

  task automatic cs_end();
    repeat (6) @(negedge clock);
    cs = 1'b1;
    repeat (8) @(negedge clock);
    check("miso_idle", miso, 1'b0);
    check("busy_idle", busy, 1'b0);
  endtask

  task automatic read_hdr(input logic [23:0] a);
    repeat (4) exp_q.push_back(8'h00);
    xfer_byte(8'h03);
    xfer_byte(a[23:16]);
    xfer_byte(a[15:8]);
    xfer_byte(a[7:0]);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    int e0;
    e0 = err_pulses;
    cs_begin();
    read_hdr(a);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_byte(int'(a) + i));
      xfer_byte(8'($urandom));
    end
    cs_end();
    check("no_err_read", err_pulses - e0, 0);
  endtask

  task automatic do_rdid(input int n);
    logic [7:0] id[4];
    id[0] = 8'hEF; id[1] = 8'h40; id[2] = 8'h16; id[3] = 8'h00;
    cs_begin();
    exp_q.push_back(8'h00);
    xfer_byte(8'h9F);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(id[(i < 3) ? i : 3]);
      xfer_byte(8'($urandom));
    end
    cs_end();
  endtask

  task automatic do_bad(input logic [7:0] op, input int n);
    int e0;
    e0 = err_pulses;
    cs_begin();
    exp_q.push_back(8'h00);
    xfer_byte(op);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'h00);
      xfer_byte(8'($urandom));
    end
    cs_end();
    check("cmd_err_once", err_pulses - e0, 1);
  endtask

  initial begin
    logic b;
    logic [7:0] op;
    repeat (3) @(negedge clock);
    check("rst_miso", miso, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_err", cmd_err, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    for (int i = 0; i < DEPTH; i++) wr_word(i, $urandom);
    wr_word(0, 32'hDEADBEEF);

    do_read(24'h000000, 4);
    do_read(24'h0007FE, 4);
    do_rdid(4);
    do_bad(8'hAB, 2);

    // Abort after three address bits, then a clean read of word 1
    cs_begin();
    exp_q.push_back(8'h00);
    xfer_byte(8'h03);
    for (int i = 0; i < 3; i++) send_bit(1'b1, b);
    cs_end();
    do_read(24'h000004, 4);

    // Reset in the middle of the third data byte
    cs_begin();
    read_hdr(24'h000010);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(exp_byte(32'h10 + i));
      xfer_byte(8'h00);
    end
    for (int i = 0; i < 4; i++) send_bit(1'b0, b);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("reset_miso", miso, 1'b0);
    check("reset_busy", busy, 1'b0);
    cs = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    do_read(24'h000010, 4);
    do_read(24'h000000, 4);

    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 7))
        6: do_rdid($urandom_range(1, 5));
        7: begin
          do op = 8'($urandom_range(0, 255)); while (op == 8'h03 || op == 8'h9F);
          do_bad(op, $urandom_range(1, 3));
        end
        default: do_read(24'($urandom), $urandom_range(1, 6));
      endcase
      if (k == 5) wr_word($urandom_range(0, DEPTH - 1), $urandom);
    end

    repeat (4) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
